// File: rtl/adc_capture_pkg.sv
// Shared types for the ADC capture block: FSM states and the captured sample word.
package adc_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2
   } state_t;

   localparam int unsigned SAMPLE_W = 11;

   // Bit 0 is the OTR flag, bits 1..10 are ADC data with bit 1 as MSB.
   typedef logic [0:SAMPLE_W-1] sample_t;

endpackage

// File: rtl/adc_capture_if.sv
// Host-side control and FIFO read bus of adc_capture.
interface adc_capture_if
   import adc_capture_pkg::*;
#(
   parameter int unsigned FIFO_AWIDTH = 4
);
   logic                 ctrl_en;
   logic                 ctrl_flush;
   logic                 ovf_clr;
   logic                 rd_en;
   sample_t              rd_data;
   logic                 empty;
   logic                 full;
   logic                 overflow;
   logic [FIFO_AWIDTH:0] count;

   modport master (
      output ctrl_en, ctrl_flush, ovf_clr, rd_en,
      input  rd_data, empty, full, overflow, count
   );

   modport slave (
      input  ctrl_en, ctrl_flush, ovf_clr, rd_en,
      output rd_data, empty, full, overflow, count
   );
endinterface

// File: rtl/adc_sync_fifo.sv
// Single-clock sample FIFO with flush, sticky overflow and registered read data.
module adc_sync_fifo #(
   parameter int unsigned WIDTH  = 11,
   parameter int unsigned AWIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             ovf_clr,
   input  logic             push,
   input  logic [0:WIDTH-1] push_data,
   input  logic             pop,
   output logic [0:WIDTH-1] rd_data,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic [AWIDTH:0]  count
);
   localparam int unsigned DEPTH = 1 << AWIDTH;
   localparam logic [AWIDTH:0] FULL_CNT = {1'b1, {AWIDTH{1'b0}}};

   logic [0:WIDTH-1]  mem [DEPTH];
   logic [AWIDTH-1:0] wr_ptr;
   logic [AWIDTH-1:0] rd_ptr;
   logic              do_push;
   logic              do_pop;
   logic              ovf_evt;

   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);

   // A pop frees a slot in the same cycle, so push-while-full with a pop is accepted.
   always_comb begin
      do_pop  = pop && !empty && !flush;
      do_push = push && !flush && (!full || do_pop);
      ovf_evt = push && !flush && full && !do_pop;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         rd_data  <= '0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + AWIDTH'(1);
            if (do_pop) begin
               rd_ptr  <= rd_ptr + AWIDTH'(1);
               rd_data <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
               2'b10:   count <= count + (AWIDTH+1)'(1);
               2'b01:   count <= count - (AWIDTH+1)'(1);
               default: count <= count;
            endcase
         end
         if (ovf_evt)      overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/adc_capture.sv
// Parallel ADC front end: generates the sample clock, discards the pipeline
// warm-up samples after each start and queues captured words in a FIFO.
module adc_capture
   import adc_capture_pkg::*;
#(
   parameter int unsigned CLK_DIV     = 4,
   parameter int unsigned ADC_LATENCY = 5,
   parameter int unsigned FIFO_AWIDTH = 4
) (
   input  logic        sys_clk_pin,
   input  logic        sys_rst_pin,
   output logic        S_Clk_pin,
   input  logic [0:9]  S_Data_pin,
   input  logic        S_OTR_pin,
   output logic        S_PWRDN_pin,
   adc_capture_if.slave bus
);
   localparam int unsigned DIV_W = $clog2(CLK_DIV);
   localparam int unsigned WRM_W = (ADC_LATENCY < 1) ? 1 : $clog2(ADC_LATENCY + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
   localparam logic [WRM_W-1:0] WRM_LOAD = WRM_W'(ADC_LATENCY);
   localparam logic [WRM_W-1:0] WRM_ONE  = WRM_W'(1);

   state_t           state, state_nxt;
   logic [DIV_W-1:0] div_cnt, div_nxt;
   logic [WRM_W-1:0] wrm_cnt, wrm_nxt;
   logic             strobe;
   logic             push_pend;
   sample_t          cap_word;

   always_comb begin
      state_nxt = state;
      wrm_nxt   = wrm_cnt;
      div_nxt   = '0;
      strobe    = bus.ctrl_en && (state != ST_IDLE) && (div_cnt == DIV_LAST);

      case (state)
         ST_IDLE: begin
            if (bus.ctrl_en) begin
               state_nxt = ST_WARMUP;
               wrm_nxt   = WRM_LOAD;
            end
         end
         ST_WARMUP: begin
            if (!bus.ctrl_en) begin
               state_nxt = ST_IDLE;
            end else if (strobe) begin
               wrm_nxt = wrm_cnt - WRM_ONE;
               if (wrm_cnt <= WRM_ONE) state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!bus.ctrl_en) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase

      // Divider runs only while staying active, so it reads 0 on entry and throughout IDLE.
      if (state != ST_IDLE && state_nxt != ST_IDLE)
         div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
   end

   always_ff @(posedge sys_clk_pin or negedge sys_rst_pin) begin
      if (!sys_rst_pin) begin
         state       <= ST_IDLE;
         div_cnt     <= '0;
         wrm_cnt     <= '0;
         S_Clk_pin   <= 1'b0;
         S_PWRDN_pin <= 1'b1;
         cap_word    <= '0;
         push_pend   <= 1'b0;
      end else begin
         state       <= state_nxt;
         div_cnt     <= div_nxt;
         wrm_cnt     <= wrm_nxt;
         S_Clk_pin   <= (state_nxt != ST_IDLE) && (div_nxt < DIV_HALF);
         S_PWRDN_pin <= (state_nxt == ST_IDLE);
         if (strobe) cap_word <= {S_OTR_pin, S_Data_pin};
         push_pend   <= strobe && (state == ST_RUN);
      end
   end

   adc_sync_fifo #(
      .WIDTH  (SAMPLE_W),
      .AWIDTH (FIFO_AWIDTH)
   ) u_fifo (
      .clk       (sys_clk_pin),
      .rst_n     (sys_rst_pin),
      .flush     (bus.ctrl_flush),
      .ovf_clr   (bus.ovf_clr),
      .push      (push_pend && bus.ctrl_en),
      .push_data (cap_word),
      .pop       (bus.rd_en),
      .rd_data   (bus.rd_data),
      .empty     (bus.empty),
      .full      (bus.full),
      .overflow  (bus.overflow),
      .count     (bus.count)
   );

endmodule

// File: tb/tb_adc_capture.sv
// Randomised scoreboard bench for adc_capture with a queue-based reference model.
module tb_adc_capture;
   import adc_capture_pkg::*;

   localparam int unsigned CLK_DIV     = 4;
   localparam int unsigned ADC_LATENCY = 5;
   localparam int unsigned FIFO_AWIDTH = 4;
   localparam int unsigned DEPTH       = 1 << FIFO_AWIDTH;
   localparam int unsigned T_SYS       = 20;
   localparam int          FIRST_PUSH  = (ADC_LATENCY + 1) * CLK_DIV + 2;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       s_clk, s_otr, s_pwrdn;
   logic [0:9] s_data;

   adc_capture_if #(.FIFO_AWIDTH(FIFO_AWIDTH)) bus ();

   adc_capture #(
      .CLK_DIV     (CLK_DIV),
      .ADC_LATENCY (ADC_LATENCY),
      .FIFO_AWIDTH (FIFO_AWIDTH)
   ) dut (
      .sys_clk_pin (clk),
      .sys_rst_pin (rst_n),
      .S_Clk_pin   (s_clk),
      .S_Data_pin  (s_data),
      .S_OTR_pin   (s_otr),
      .S_PWRDN_pin (s_pwrdn),
      .bus         (bus)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: session/sample arithmetic plus a queue standing in for the FIFO.
   logic        m_active = 1'b0;
   int unsigned m_cyc = 0;
   int unsigned m_k = 0;
   logic        m_pend = 1'b0;
   sample_t     m_pend_word;
   sample_t     m_q[$];
   logic        m_ovf = 1'b0;
   sample_t     exp_q[$];
   logic        pop_evt = 1'b0;
   logic        adv = 1'b0;

   logic        ramp_mode = 1'b1;
   int          sample_idx = 0;
   int          otr_idx = -1;

   task automatic model_reset();
      m_active = 1'b0;
      m_cyc    = 0;
      m_k      = 0;
      m_pend   = 1'b0;
      m_q.delete();
      m_ovf    = 1'b0;
      exp_q.delete();
      pop_evt  = 1'b0;
      adv      = 1'b0;
   endtask

   task automatic model_step();
      logic    push_now, pop_ok, ovf_evt;
      sample_t w;
      pop_evt  = 1'b0;
      ovf_evt  = 1'b0;
      w        = m_pend_word;
      push_now = m_pend && bus.ctrl_en && m_active;
      m_pend   = 1'b0;
      if (!bus.ctrl_en) begin
         m_active = 1'b0;
      end else if (!m_active) begin
         m_active = 1'b1;
         m_cyc    = 0;
         m_k      = 0;
      end else begin
         m_cyc++;
         if (m_cyc % CLK_DIV == 0) begin
            m_k++;
            adv = 1'b1;
            if (m_k > ADC_LATENCY) begin
               m_pend      = 1'b1;
               m_pend_word = {s_otr, s_data};
            end
         end
      end
      if (bus.ctrl_flush) begin
         m_q.delete();
      end else begin
         pop_ok = bus.rd_en && (m_q.size() > 0);
         if (push_now && m_q.size() == DEPTH && !pop_ok) ovf_evt = 1'b1;
         if (pop_ok) begin
            exp_q.push_back(m_q.pop_front());
            pop_evt = 1'b1;
         end
         if (push_now && m_q.size() < DEPTH) m_q.push_back(w);
      end
      if (ovf_evt)          m_ovf = 1'b1;
      else if (bus.ovf_clr) m_ovf = 1'b0;
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   // ADC model: a new sample appears after each sample strobe.
   initial begin
      s_data = '0;
      s_otr  = 1'b0;
      forever begin
         @(negedge clk);
         if (adv) begin
            adv = 1'b0;
            sample_idx++;
            if (ramp_mode) begin
               s_data = sample_idx[9:0];
               s_otr  = (sample_idx == otr_idx);
            end else begin
               s_data = 10'($urandom);
               s_otr  = ($urandom_range(0, 7) == 0);
            end
         end
      end
   end

   // Monitor: popped words against the scoreboard, status against the model every cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (pop_evt) begin
            if (exp_q.size() > 0) chk("rd_data", int'(bus.rd_data), int'(exp_q.pop_front()));
            else                  chk("rd_data_unexpected", 1, 0);
         end
         chk("count",    int'(bus.count), m_q.size());
         chk("empty",    int'(bus.empty), int'(m_q.size() == 0));
         chk("full",     int'(bus.full), int'(m_q.size() == DEPTH));
         chk("overflow", int'(bus.overflow), int'(m_ovf));
         chk("pwrdn",    int'(s_pwrdn), int'(!m_active));
         chk("s_clk",    int'(s_clk), int'(m_active && ((m_cyc % CLK_DIV) < CLK_DIV / 2)));
      end
   end

   task automatic wait_pend(input string name);
      int n = 0;
      while (!m_pend && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!m_pend) chk(name, 0, 1);
   endtask

   initial begin
      int cyc;
      int rise_at[$];
      logic prev;
      int rd_pct;

      bus.ctrl_en    = 1'b0;
      bus.ctrl_flush = 1'b0;
      bus.ovf_clr    = 1'b0;
      bus.rd_en      = 1'b0;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_count",    int'(bus.count), 0);
      chk("rst_empty",    int'(bus.empty), 1);
      chk("rst_full",     int'(bus.full), 0);
      chk("rst_overflow", int'(bus.overflow), 0);
      chk("rst_rd_data",  int'(bus.rd_data), 0);
      chk("rst_s_clk",    int'(s_clk), 0);
      chk("rst_pwrdn",    int'(s_pwrdn), 1);
      #3 rst_n = 1'b1;
      @(negedge clk);

      // Start-up latency, sample clock period, ramp with one OTR sample.
      ramp_mode   = 1'b1;
      otr_idx     = 12;
      bus.ctrl_en = 1'b1;
      cyc = 0;
      while (bus.count == 0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) chk("pwrdn_fall", int'(s_pwrdn), 0);
      end
      chk("first_push_latency", cyc, FIRST_PUSH);
      for (int i = 0; i < 3 * CLK_DIV; i++) begin
         prev = s_clk;
         @(negedge clk);
         if (s_clk && !prev) rise_at.push_back(i);
      end
      if (rise_at.size() >= 2) chk("s_clk_period_ns", (rise_at[1] - rise_at[0]) * T_SYS, CLK_DIV * T_SYS);
      else                     chk("s_clk_rises", rise_at.size(), 2);
      for (int i = 0; i < 40 * CLK_DIV; i++) begin
         bus.rd_en = ($urandom_range(0, 1) == 1);
         @(negedge clk);
      end
      otr_idx     = -1;
      bus.ctrl_en = 1'b0;
      bus.rd_en   = 1'b1;
      for (int i = 0; i < 40 && m_q.size() > 0; i++) @(negedge clk);
      bus.rd_en = 1'b0;
      chk("drained_empty", int'(bus.empty), 1);

      // Fill past capacity with no reads.
      bus.ctrl_flush = 1'b1;
      @(negedge clk);
      bus.ctrl_flush = 1'b0;
      bus.ctrl_en    = 1'b1;
      repeat ((ADC_LATENCY + 20) * CLK_DIV + 2) @(negedge clk);
      chk("fill_count",    int'(bus.count), DEPTH);
      chk("fill_full",     int'(bus.full), 1);
      chk("fill_overflow", int'(bus.overflow), 1);
      bus.ctrl_en = 1'b0;
      @(negedge clk);
      bus.ovf_clr = 1'b1;
      @(negedge clk);
      bus.ovf_clr = 1'b0;
      chk("ovf_cleared", int'(bus.overflow), 0);

      // Full FIFO with a pop on every push cycle.
      bus.ctrl_en = 1'b1;
      for (int i = 0; i < (ADC_LATENCY + 10) * CLK_DIV; i++) begin
         bus.rd_en = m_pend;
         @(negedge clk);
      end
      bus.rd_en = 1'b0;
      chk("push_pop_full_count", int'(bus.count), DEPTH);
      chk("push_pop_full_ovf",   int'(bus.overflow), 0);

      // Clear coincident with a new overflow event leaves overflow set.
      wait_pend("ovf_race_timeout");
      bus.ovf_clr = 1'b1;
      @(negedge clk);
      bus.ovf_clr = 1'b0;
      chk("ovf_clr_vs_event", int'(bus.overflow), 1);

      // Stop/restart: contents retained, power-down follows enable.
      bus.ctrl_en = 1'b0;
      bus.rd_en   = 1'b1;
      repeat (5) @(negedge clk);
      bus.rd_en = 1'b0;
      chk("drain5_count", int'(bus.count), DEPTH - 5);
      bus.ctrl_en = 1'b1;
      repeat ((ADC_LATENCY + 3) * CLK_DIV + $urandom_range(0, CLK_DIV - 1)) @(negedge clk);
      bus.ctrl_en = 1'b0;
      @(negedge clk);
      chk("stop_pwrdn", int'(s_pwrdn), 1);
      cyc = int'(bus.count);
      repeat (10) @(negedge clk);
      chk("stop_retained", int'(bus.count), cyc);
      bus.ctrl_en = 1'b1;
      @(negedge clk);
      chk("restart_pwrdn", int'(s_pwrdn), 0);
      repeat ((ADC_LATENCY + 2) * CLK_DIV) @(negedge clk);

      // Reset mid-capture with seven entries held.
      bus.ctrl_en    = 1'b0;
      bus.ctrl_flush = 1'b1;
      @(negedge clk);
      bus.ctrl_flush = 1'b0;
      bus.ctrl_en    = 1'b1;
      for (int i = 0; i < 200 && m_q.size() != 7; i++) @(negedge clk);
      chk("seven_held", int'(bus.count), 7);
      #3 rst_n = 1'b0;
      #2;
      chk("rst_mid_count", int'(bus.count), 0);
      chk("rst_mid_empty", int'(bus.empty), 1);
      chk("rst_mid_pwrdn", int'(s_pwrdn), 1);
      chk("rst_mid_s_clk", int'(s_clk), 0);
      @(negedge clk);
      #3 rst_n = 1'b1;
      cyc = 0;
      while (bus.count == 0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("restart_latency", cyc, FIRST_PUSH);

      // Random traffic: random data, read rates, flushes, clears and enable toggles.
      ramp_mode = 1'b0;
      rd_pct    = 25;
      for (int i = 0; i < 2400; i++) begin
         if (i % 200 == 0) rd_pct = (($urandom_range(0, 2) == 0) ? 5 : (($urandom_range(0, 1) == 0) ? 25 : 60));
         bus.rd_en      = ($urandom_range(0, 99) < rd_pct);
         bus.ctrl_flush = ($urandom_range(0, 199) == 0);
         bus.ovf_clr    = ($urandom_range(0, 49) == 0);
         if (bus.ctrl_en) begin
            if ($urandom_range(0, 149) == 0) bus.ctrl_en = 1'b0;
         end else if ($urandom_range(0, 9) == 0) begin
            bus.ctrl_en = 1'b1;
         end
         @(negedge clk);
      end
      bus.ctrl_en    = 1'b0;
      bus.ctrl_flush = 1'b0;
      bus.ovf_clr    = 1'b0;
      bus.rd_en      = 1'b0;
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
